// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and elaboration helpers for pipelined_adder
//   OP_ADD / OP_SUB : op input encoding
//   chunk_width()   : bits handled per pipeline stage
//   params_ok()     : legality of a WIDTH/STAGES pair
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CW-bit ripple-carry adder slice
//   a, b : CW-bit operands (b arrives pre-inverted for subtract)
//   cin  : carry into bit 0
//   s    : CW-bit sum
//   co   : carry out of the top bit
module adder_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          co
);

  // Carry is a loop-local variable so the ripple is one acyclic block.
  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i < CW; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep pipelined add/subtract with valid/ready flow control
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_ready : input handshake; in_ready is combinational from out_ready
//   a, b, cin, op      : operands, carry/borrow in, 0 = add / 1 = subtract
//   out_valid, out_ready : output handshake
//   sum, cout, sat     : registered result, raw carry out, saturation flag
//   Optional feature: define ADDER_SAT_EN for unsigned saturation; otherwise sat = 0.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sat
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $fatal(1, "pipelined_adder: WIDTH must be >= 2 and divisible by STAGES >= 1");
  end

  // Subtract is a + ~b + ~cin; the inversion is applied once at the input so
  // the stored upper b bits are already in adder form.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = (op == OP_ADD) ? b : ~b;
  assign cin_eff = (op == OP_SUB) ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                v_q;
    logic                v_d;
    logic                load;
    logic [CW-1:0]       ca;
    logic [CW-1:0]       cb;
    logic [CW-1:0]       cs;
    logic                ci;
    logic                co;
    logic                c_q;
    logic [(k+1)*CW-1:0] s_raw;
    logic [(k+1)*CW-1:0] s_d;
    logic [(k+1)*CW-1:0] s_q;
`ifdef ADDER_SAT_EN
    logic                op_d;
`endif

    // A stage may load if it is empty or if the stage after it is loading,
    // which lets bubbles collapse under back-pressure.
    if (k == STAGES-1) begin : g_load
      assign load = !v_q || out_ready;
    end else begin : g_load
      assign load = !v_q || g_stage[k+1].load;
    end

    if (k == 0) begin : g_src
      assign v_d   = in_valid;
      assign ca    = a[CW-1:0];
      assign cb    = b_eff[CW-1:0];
      assign ci    = cin_eff;
      assign s_raw = cs;
`ifdef ADDER_SAT_EN
      assign op_d  = op;
`endif
    end else begin : g_src
      assign v_d   = g_stage[k-1].v_q;
      assign ca    = g_stage[k-1].g_ops.ha_q[CW-1:0];
      assign cb    = g_stage[k-1].g_ops.hb_q[CW-1:0];
      assign ci    = g_stage[k-1].c_q;
      assign s_raw = {cs, g_stage[k-1].s_q};
`ifdef ADDER_SAT_EN
      assign op_d  = g_stage[k-1].g_ops.op_q;
`endif
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a   (ca),
      .b   (cb),
      .cin (ci),
      .s   (cs),
      .co  (co)
    );

    // Operand bits not yet summed, right-aligned so the next stage always
    // consumes the low CW bits. The last stage has nothing left to carry.
    if (k < STAGES-1) begin : g_ops
      logic [WIDTH-(k+1)*CW-1:0] ha_d;
      logic [WIDTH-(k+1)*CW-1:0] hb_d;
      logic [WIDTH-(k+1)*CW-1:0] ha_q;
      logic [WIDTH-(k+1)*CW-1:0] hb_q;
`ifdef ADDER_SAT_EN
      logic                      op_q;
`endif

      if (k == 0) begin : g_in
        assign ha_d = a[WIDTH-1:CW];
        assign hb_d = b_eff[WIDTH-1:CW];
      end else begin : g_in
        assign ha_d = g_stage[k-1].g_ops.ha_q[WIDTH-k*CW-1:CW];
        assign hb_d = g_stage[k-1].g_ops.hb_q[WIDTH-k*CW-1:CW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ha_q <= '0;
          hb_q <= '0;
`ifdef ADDER_SAT_EN
          op_q <= 1'b0;
`endif
        end else if (load) begin
          ha_q <= ha_d;
          hb_q <= hb_d;
`ifdef ADDER_SAT_EN
          op_q <= op_d;
`endif
        end
      end
    end

    if (k == STAGES-1) begin : g_out
`ifdef ADDER_SAT_EN
      logic sat_d;
      logic sat_q;

      // Add overflows on carry; subtract underflows when no carry (borrow).
      assign sat_d = (op_d == OP_ADD) ? co : ~co;
      assign s_d   = !sat_d ? s_raw : ((op_d == OP_ADD) ? '1 : '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          sat_q <= 1'b0;
        end else if (load) begin
          sat_q <= sat_d;
        end
      end
`else
      assign s_d = s_raw;
`endif
    end else begin : g_out
      assign s_d = s_raw;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (load) begin
        v_q <= v_d;
        s_q <= s_d;
        c_q <= co;
      end
    end
  end

  assign in_ready  = g_stage[0].load;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
`ifdef ADDER_SAT_EN
  assign sat       = g_stage[STAGES-1].g_out.sat_q;
`else
  assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (WIDTH=8, STAGES=2)
module tb_pipelined_adder;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             sat;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_pop   = 0;
  int         cyc     = 0;
  logic [9:0] q[$];
  logic [7:0] got[$];
  int         pop_cyc[$];
  logic       last_acc;
  logic       last_in_ready;
  logic       last_out_valid;
  logic [7:0] last_sum;
  logic       last_cout;
  logic       last_sat;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_sum;

  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic o);
    logic [8:0] t;
    logic       s;
    if (!o) t = {1'b0, x} + {1'b0, y} + {8'd0, ci};
    else    t = {1'b0, x} + {1'b0, ~y} + {8'd0, ~ci};
    s = 1'b0;
`ifdef ADDER_SAT_EN
    if (!o && t[8]) begin t[7:0] = 8'hFF; s = 1'b1; end
    if (o && !t[8]) begin t[7:0] = 8'h00; s = 1'b1; end
`endif
    return {s, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample settled outputs, retire/record beats, then cross the edge.
  task automatic tick();
    logic [9:0] e;
    #1;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    last_acc       = in_valid && in_ready && !rst;
    if (stall_prev) begin
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold_sum", {24'd0, sum}, {24'd0, prev_sum});
    end
    stall_prev = out_valid && !out_ready;
    prev_sum   = sum;
    if (out_valid === 1'b1 && out_ready === 1'b1 && !rst) begin
      chk("spurious_output", {31'd0, (q.size() > 0)}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_sum", {24'd0, sum}, {24'd0, e[7:0]});
        chk("sb_cout", {31'd0, cout}, {31'd0, e[8]});
        chk("sb_sat", {31'd0, sat}, {31'd0, e[9]});
      end
      n_pop++;
      got.push_back(sum);
      pop_cyc.push_back(cyc);
      last_sum  = sum;
      last_cout = cout;
      last_sat  = sat;
    end
    e = model(a, b, cin, op);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else if (last_acc) begin
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send_one(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                          input logic xc, input logic xo, input logic [7:0] es,
                          input logic ec, input logic et);
    int base;
    int waited;
    a = xa; b = xb; cin = xc; op = xo; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk({tag, "_accept"}, {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    base   = n_pop;
    waited = 0;
    while (n_pop == base && waited < 10) begin
      tick();
      waited++;
    end
    chk({tag, "_latency"}, waited, STAGES);
    chk({tag, "_sum"}, {24'd0, last_sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, last_cout}, {31'd0, ec});
    chk({tag, "_sat"}, {31'd0, last_sat}, {31'd0, et});
    tick();
    chk({tag, "_one_cycle"}, {31'd0, last_out_valid}, 32'd0);
  endtask

  initial begin
    int j;
    int base;
    int guard;
    rst = 1'b1; in_valid = 1'b1; a = 8'h33; b = 8'h01; cin = 1'b0; op = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_no_accept", n_pop, 0);

    send_one("add_basic", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
`ifdef ADDER_SAT_EN
    send_one("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
    send_one("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
`else
    send_one("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    send_one("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
`endif
    send_one("sub_plain", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    send_one("add_cin", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0);

    got.delete();
    pop_cyc.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      a = 8'(i); b = 8'(2 * i); cin = 1'b0; op = 1'b0; in_valid = 1'b1;
      tick();
      chk("stream_in_ready", {31'd0, last_in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin tick(); guard++; end
    chk("stream_count", got.size(), 6);
    if (got.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("stream_value", {24'd0, got[i]}, 3 * (i + 1));
      chk("stream_rate", pop_cyc[5] - pop_cyc[0], 5);
    end

    base = n_pop;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    j = 0;
    for (int c = 0; c < 5; c++) begin
      a = 8'h10 + 8'(j); b = 8'(j * 3); cin = j[0]; op = ((j % 3) == 2);
      tick();
      if (last_acc) j++;
      if (c >= 2) chk("bp_in_ready_low", {31'd0, last_in_ready}, 32'd0);
    end
    chk("bp_held_count", j, STAGES);
    out_ready = 1'b1;
    guard = 0;
    while (j < 8 && guard < 30) begin
      a = 8'h10 + 8'(j); b = 8'(j * 3); cin = j[0]; op = ((j % 3) == 2);
      tick();
      if (last_acc) j++;
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin tick(); guard++; end
    chk("bp_drained", q.size(), 0);
    chk("bp_delivered_once", n_pop - base, j);

    base = n_pop;
    out_ready = 1'b0;
    a = 8'h21; b = 8'h12; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    tick();
    chk("rstmf_accept0", {31'd0, last_acc}, 32'd1);
    a = 8'h40; b = 8'h02;
    tick();
    chk("rstmf_accept1", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmf_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmf_sum", {24'd0, sum}, 32'd0);
    chk("rstmf_cout", {31'd0, cout}, 32'd0);
    chk("rstmf_sat", {31'd0, sat}, 32'd0);
    chk("rstmf_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rstmf_no_ghost", n_pop - base, 0);

    send_one("post_rst_add", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    chk("sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit: the next generation of the 3-bit registered ripple adder. Operands of WIDTH bits are split into STAGES equal chunks, with one registered ripple chunk per pipeline stage and the carry passed stage to stage. A valid/ready handshake on both sides allows back-pressure, with bubble collapsing and no data loss. It sits between operand sources and downstream accumulate/compare logic in the arithmetic datapath.

## Interface
- WIDTH, 8, operand and sum width; must be ≥ 2.
- STAGES, 2, number of pipeline stages; must divide WIDTH exactly. Chunk width CW = WIDTH/STAGES.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  downstream takes the result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry-out. In sub mode, 1 means no borrow.
- sat  out  1  result was saturated; constant 0 without the macro.

## Operation
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: {cout,sum} = a + ~b + ~cin, i.e. a − b − cin.
  - Results are exact modulo 2^WIDTH.
- Stage k (0..STAGES−1) holds a valid bit v[k] and:
  - registered chunk-k sum bits plus all lower sum bits;
  - the unprocessed upper bits of a and b (b already inverted for sub);
  - the carry out of chunk k;
  - op.
- Stage 0 computes chunk 0 from the inputs. Stage k computes chunk k from stage k−1's register and carry.
- Load rule:
  - load[STAGES−1] = !v[STAGES−1] | out_ready.
  - load[k] = !v[k] | load[k+1].
  - in_ready = load[0]. This is combinational from out_ready (no skid buffer).
- Transfer rules:
  - Stage k captures stage k−1 data and validity when load[k]. Stage 0 captures the inputs with v[0] = in_valid & in_ready.
  - A stage that is not loading holds its contents unchanged.
- Outputs come from the last stage: out_valid = v[STAGES−1]; sum, cout and sat are registered values.
- sum, cout and sat are held stable while out_valid & !out_ready.
- Order is strictly preserved. No beat is dropped or duplicated.
- Reset:
  - clears every v[k] and every data register;
  - out_valid = 0, sum = 0, cout = 0, sat = 0 on the cycle after rst is sampled high;
  - in_ready = 1 on that cycle;
  - in-flight beats are discarded, and a beat offered while rst is high is not accepted.

## Timing
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, i.e. it is visible STAGES cycles after in_valid & in_ready is sampled, assuming no stall.
- Throughput is one beat per cycle while out_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0. The pipeline holds STAGES beats.
- Bubbles collapse: an empty stage loads even when downstream is stalled.
- Simultaneous out_ready and in_valid with a full pipeline: one beat leaves and one beat enters in the same cycle.
- Critical path: one CW-bit ripple plus the load chain.

## Configuration
- ADDER_SAT_EN defined, unsigned saturation is applied in the last stage:
  - add with carry-out = 1 → sum = all ones, sat = 1;
  - sub with carry-out = 0 (borrow) → sum = 0, sat = 1;
  - cout still reports the raw carry.
- ADDER_SAT_EN undefined: wrap-around result, and sat is tied to 0.

## Structure
- Package adder_pkg:
  - op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - function chunk_width(WIDTH, STAGES);
  - parameter-legality checks (elaboration error if WIDTH % STAGES ≠ 0 or STAGES < 1).
- Sub-module adder_chunk (parameter CW): combinational CW-bit ripple of full adders, with inputs a, b, cin and outputs s, co. It is instantiated once per stage via generate.
- The top level holds only the stage registers, the valid/load chain and the saturation logic.

## Test plan
All scenarios use WIDTH = 8, STAGES = 2.
- Basic add: op = 0, a = 8'h0F, b = 8'h01, cin = 0, out_ready = 1 → after 2 cycles sum = 8'h10, cout = 0, sat = 0; out_valid high for exactly 1 cycle.
- Carry across chunks and wrap: a = 8'hFF, b = 8'h01, cin = 0 → sum = 8'h00, cout = 1. With ADDER_SAT_EN: sum = 8'hFF, sat = 1.
- Subtract with borrow: op = 1, a = 8'h05, b = 8'h07, cin = 0 → sum = 8'hFE, cout = 0. With ADDER_SAT_EN: sum = 8'h00, sat = 1. Also a = 8'h07, b = 8'h05 → sum = 8'h02, cout = 1.
- Streaming: 6 back-to-back beats (i, 2i) for i = 1..6, out_ready = 1 → one result per cycle (3, 6, 9, 12, 15, 18), in order; in_ready never drops.
- Back-pressure: stream continuously and hold out_ready = 0 for 5 cycles → in_ready = 0 once 2 beats are held; outputs stay stable; after release every beat arrives exactly once and in order.
- Reset mid-flight: assert rst for 1 cycle with 2 beats in flight → next cycle out_valid = 0, sum = 0, cout = 0, sat = 0, in_ready = 1; the held beats never appear.
